// File: rtl/count_wrap_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : count_wrap_tracker_if
//  Description : Signal bundle between a 4-bit up counter's observer side and
//                the count_wrap_tracker block.
//                master : drives the sampled counter signals and controls
//                         (count_in, load, load_val, enable, clr_err) and
//                         receives the tracker status.
//                slave  : the tracker itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface count_wrap_tracker_if;
    logic [3:0] count_in;
    logic       load;
    logic [3:0] load_val;
    logic       enable;
    logic       clr_err;
    logic       wrap_pulse;
    logic [7:0] wrap_cnt;
    logic       seq_err;
    logic [3:0] err_cnt;
    logic [1:0] state;

    modport master (
        output count_in, load, load_val, enable, clr_err,
        input  wrap_pulse, wrap_cnt, seq_err, err_cnt, state
    );

    modport slave (
        input  count_in, load, load_val, enable, clr_err,
        output wrap_pulse, wrap_cnt, seq_err, err_cnt, state
    );
endinterface
`default_nettype wire

// File: rtl/count_wrap_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : count_wrap_tracker
//  Description : Watches the output of a free-running 4-bit up counter (and
//                its load strobe), counts natural 15->0 rollovers and flags
//                any sample that does not follow the expected sequence.
//  Ports       : clock          system clock, shared with the counter
//                rst            synchronous active-high reset
//                bus.count_in   counter output, sampled every rising edge
//                bus.load       counter load strobe
//                bus.load_val   counter load data
//                bus.enable     tracking enable (level)
//                bus.clr_err    clears seq_err / err_cnt
//                bus.wrap_pulse one-cycle pulse per natural rollover
//                bus.wrap_cnt   rollover count, modulo 256
//                bus.seq_err    sticky sequence-error flag
//                bus.err_cnt    mismatch count, saturating at 15
//                bus.state      IDLE=0, SYNC=1, TRACK=2, ERROR=3
//  Revision    : 1.0 - initial release
// ============================================================================
module count_wrap_tracker (
    input  wire logic           clock,
    input  wire logic           rst,
    count_wrap_tracker_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_TRACK = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam logic [3:0] C_ERR_MAX = 4'd15;
    localparam logic [3:0] C_CNT_MAX = 4'd15;

    state_t     r_state;
    logic [3:0] r_prev;
    logic       r_ld_q;
    logic [3:0] r_ldv_q;
    logic       r_wrap_pulse;
    logic [7:0] r_wrap_cnt;
    logic       r_seq_err;
    logic [3:0] r_err_cnt;

    logic [3:0] w_exp;
    logic       w_match;
    logic       w_wrap;

    // The counter either loaded last cycle or incremented (mod 16).
    assign w_exp   = r_ld_q ? r_ldv_q : (r_prev + 4'd1);
    assign w_match = (bus.count_in == w_exp);
    // Only an increment from 15 counts as a rollover; a load that lands on 0
    // produces the same count_in but must not be counted.
    assign w_wrap  = w_match && !r_ld_q && (r_prev == C_CNT_MAX) && (bus.count_in == 4'd0);

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_prev       <= 4'd0;
            r_ld_q       <= 1'b0;
            r_ldv_q      <= 4'd0;
            r_wrap_pulse <= 1'b0;
            r_wrap_cnt   <= 8'd0;
            r_seq_err    <= 1'b0;
            r_err_cnt    <= 4'd0;
        end else begin
            r_wrap_pulse <= 1'b0;

            // A mismatch in TRACK below overrides this clear.
            if (bus.clr_err) begin
                r_seq_err <= 1'b0;
                r_err_cnt <= 4'd0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        r_state <= S_SYNC;
                    end
                end

                S_SYNC: begin
                    r_prev  <= bus.count_in;
                    r_ld_q  <= bus.load;
                    r_ldv_q <= bus.load_val;
                    r_state <= bus.enable ? S_TRACK : S_IDLE;
                end

                S_TRACK: begin
                    if (!bus.enable) begin
                        r_state <= S_IDLE;
                    end else if (w_match) begin
                        r_prev  <= bus.count_in;
                        r_ld_q  <= bus.load;
                        r_ldv_q <= bus.load_val;
                        if (w_wrap) begin
                            r_wrap_pulse <= 1'b1;
                            r_wrap_cnt   <= r_wrap_cnt + 8'd1;
                        end
                    end else begin
                        r_seq_err <= 1'b1;
                        if (bus.clr_err) begin
                            r_err_cnt <= 4'd1;
                        end else if (r_err_cnt != C_ERR_MAX) begin
                            r_err_cnt <= r_err_cnt + 4'd1;
                        end
                        r_state <= S_ERROR;
                    end
                end

                S_ERROR: begin
                    // No compare here; SYNC re-captures the live count.
                    r_state <= bus.enable ? S_SYNC : S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.state      = r_state;
    assign bus.wrap_pulse = r_wrap_pulse;
    assign bus.wrap_cnt   = r_wrap_cnt;
    assign bus.seq_err    = r_seq_err;
    assign bus.err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_count_wrap_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_wrap_tracker
//  Description : Directed testbench for count_wrap_tracker. The stimulus
//                process emulates the 4-bit counter and queues hand-computed
//                expected outputs; a monitor on the falling edge pops and
//                compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_count_wrap_tracker;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    count_wrap_tracker_if bus ();

    count_wrap_tracker dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [1:0] st;
        logic       wp;
        logic [7:0] wc;
        logic       se;
        logic [3:0] ec;
    } exp_t;

    exp_t       sb[$];
    int         cyc       = 0;
    int         n_checks  = 0;
    int         n_errors  = 0;
    logic [3:0] cnt;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compares every expectation queued for the current cycle.
    always @(negedge clock) begin
        exp_t e;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (bus.state !== e.st || bus.wrap_pulse !== e.wp || bus.wrap_cnt !== e.wc ||
                bus.seq_err !== e.se || bus.err_cnt !== e.ec) begin
                n_errors++;
                $display("FAIL %s @cyc %0d: got state=%0d wp=%0b wc=%0d se=%0b ec=%0d, required state=%0d wp=%0b wc=%0d se=%0b ec=%0d",
                         e.name, cyc, bus.state, bus.wrap_pulse, bus.wrap_cnt, bus.seq_err, bus.err_cnt,
                         e.st, e.wp, e.wc, e.se, e.ec);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string n, input logic [1:0] st, input logic wp,
                              input logic [7:0] wc, input logic se, input logic [3:0] ec);
        exp_t e;
        e.cyc  = cyc;
        e.name = n;
        e.st   = st;
        e.wp   = wp;
        e.wc   = wc;
        e.se   = se;
        e.ec   = ec;
        sb.push_back(e);
    endtask

    // Present the counter's current value for one edge, then advance it.
    task automatic step_cnt(input logic ld, input logic [3:0] lv);
        bus.count_in = cnt;
        bus.load     = ld;
        bus.load_val = lv;
        tick();
        cnt = ld ? lv : cnt + 4'd1;
    endtask

    // Corrupt count_in for one edge while the real counter keeps counting.
    task automatic step_force(input logic [3:0] v);
        bus.count_in = v;
        bus.load     = 1'b0;
        tick();
        cnt = cnt + 4'd1;
    endtask

    task automatic restart(input logic [3:0] start);
        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.clr_err  = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 4'd0;
        cnt          = start;
        bus.count_in = start;
        tick();
        expect_out("reset", 2'd0, 1'b0, 8'd0, 1'b0, 4'd0);
        rst        = 1'b0;
        bus.enable = 1'b1;
        step_cnt(1'b0, 4'd0);
        expect_out("enter_sync", 2'd1, 1'b0, 8'd0, 1'b0, 4'd0);
        step_cnt(1'b0, 4'd0);
        expect_out("enter_track", 2'd2, 1'b0, 8'd0, 1'b0, 4'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] d;

        // Free run from 0: edges k=1,2 are SYNC/TRACK entry; count (k-1)%16.
        restart(4'd0);
        for (int k = 3; k <= 40; k++) begin
            step_cnt(1'b0, 4'd0);
            expect_out("free_run", 2'd2, (k == 17) || (k == 33),
                       (k >= 33) ? 8'd2 : ((k >= 17) ? 8'd1 : 8'd0), 1'b0, 4'd0);
        end

        // Load 9 while the count is 4, then keep following.
        restart(4'd2);
        step_cnt(1'b1, 4'd9);
        expect_out("load_at_4", 2'd2, 1'b0, 8'd0, 1'b0, 4'd0);
        step_cnt(1'b0, 4'd0);
        expect_out("load_val_9", 2'd2, 1'b0, 8'd0, 1'b0, 4'd0);
        step_cnt(1'b0, 4'd0);
        expect_out("after_load_10", 2'd2, 1'b0, 8'd0, 1'b0, 4'd0);
        step_cnt(1'b0, 4'd0);
        expect_out("after_load_11", 2'd2, 1'b0, 8'd0, 1'b0, 4'd0);

        // Load 0 from 15 is not a wrap; the following natural rollover is.
        step_cnt(1'b0, 4'd0);
        step_cnt(1'b0, 4'd0);
        step_cnt(1'b0, 4'd0);
        step_cnt(1'b1, 4'd0);
        expect_out("load0_at_15", 2'd2, 1'b0, 8'd0, 1'b0, 4'd0);
        step_cnt(1'b0, 4'd0);
        expect_out("load0_nowrap", 2'd2, 1'b0, 8'd0, 1'b0, 4'd0);
        for (int i = 1; i <= 15; i++) step_cnt(1'b0, 4'd0);
        step_cnt(1'b0, 4'd0);
        expect_out("natural_wrap", 2'd2, 1'b1, 8'd1, 1'b0, 4'd0);
        step_cnt(1'b0, 4'd0);
        expect_out("pulse_single", 2'd2, 1'b0, 8'd1, 1'b0, 4'd0);

        // Count 7 when 3 expected.
        step_cnt(1'b0, 4'd0);
        step_force(4'd7);
        expect_out("mismatch_err", 2'd3, 1'b0, 8'd1, 1'b1, 4'd1);
        step_cnt(1'b0, 4'd0);
        expect_out("err_to_sync", 2'd1, 1'b0, 8'd1, 1'b1, 4'd1);
        step_cnt(1'b0, 4'd0);
        expect_out("sync_to_track", 2'd2, 1'b0, 8'd1, 1'b1, 4'd1);
        step_cnt(1'b0, 4'd0);
        expect_out("err_sticky", 2'd2, 1'b0, 8'd1, 1'b1, 4'd1);

        // Clear, then 17 mismatches saturate at 15.
        bus.clr_err = 1'b1;
        step_cnt(1'b0, 4'd0);
        bus.clr_err = 1'b0;
        expect_out("clr_err", 2'd2, 1'b0, 8'd1, 1'b0, 4'd0);
        for (int i = 1; i <= 17; i++) begin
            step_force(cnt ^ 4'h8);
            expect_out("err_sat", 2'd3, 1'b0, 8'd1, 1'b1, (i > 15) ? 4'd15 : 4'(i));
            step_cnt(1'b0, 4'd0);
            step_cnt(1'b0, 4'd0);
        end
        bus.clr_err = 1'b1;
        step_force(cnt ^ 4'h8);
        bus.clr_err = 1'b0;
        expect_out("clr_vs_mismatch", 2'd3, 1'b0, 8'd1, 1'b1, 4'd1);
        step_cnt(1'b0, 4'd0);
        expect_out("resync", 2'd1, 1'b0, 8'd1, 1'b1, 4'd1);
        step_cnt(1'b0, 4'd0);
        expect_out("retrack", 2'd2, 1'b0, 8'd1, 1'b1, 4'd1);

        // Disable drops to IDLE with counters held.
        bus.enable = 1'b0;
        step_cnt(1'b0, 4'd0);
        expect_out("disable_idle", 2'd0, 1'b0, 8'd1, 1'b1, 4'd1);
        step_cnt(1'b0, 4'd0);
        expect_out("idle_hold", 2'd0, 1'b0, 8'd1, 1'b1, 4'd1);
        bus.enable = 1'b1;
        step_cnt(1'b0, 4'd0);
        expect_out("reenable_sync", 2'd1, 1'b0, 8'd1, 1'b1, 4'd1);
        step_cnt(1'b0, 4'd0);
        step_cnt(1'b0, 4'd0);
        expect_out("reenable_track", 2'd2, 1'b0, 8'd1, 1'b1, 4'd1);

        // Five wraps, then reset mid-TRACK.
        restart(4'd0);
        for (int w = 1; w <= 5; w++) begin
            d = 4'd1;
            while (d != 4'd0) begin
                d = cnt;
                step_cnt(1'b0, 4'd0);
            end
            expect_out("wrap5", 2'd2, 1'b1, w[7:0], 1'b0, 4'd0);
        end
        step_cnt(1'b0, 4'd0);
        expect_out("wrap5_hold", 2'd2, 1'b0, 8'd5, 1'b0, 4'd0);
        rst = 1'b1;
        step_cnt(1'b0, 4'd0);
        rst = 1'b0;
        expect_out("rst_mid_track", 2'd0, 1'b0, 8'd0, 1'b0, 4'd0);

        // 256 natural wraps: wrap_cnt rolls back to 0.
        restart(4'd0);
        for (int w = 1; w <= 256; w++) begin
            d = 4'd1;
            while (d != 4'd0) begin
                d = cnt;
                step_cnt(1'b0, 4'd0);
            end
            expect_out("wrap256", 2'd2, 1'b1, w[7:0], 1'b0, 4'd0);
        end
        step_cnt(1'b0, 4'd0);
        expect_out("wrap256_end", 2'd2, 1'b0, 8'd0, 1'b0, 4'd0);

        repeat (3) tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations unchecked, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_wrap_tracker.md
COUNT_WRAP_TRACKER -- requirements
Module: count_wrap_tracker

Interface
REQ-001 The block SHALL use one clock, clock, and a synchronous, active-high reset, rst; all state changes occur only on the rising edge of clock.
REQ-002 Port: clock  in  1  system clock, shared with the 4-bit up counter.
REQ-003 Port: rst  in  1  synchronous active-high reset, shared with the counter.
REQ-004 Port: count_in  in  4  counter data_out, sampled every rising edge.
REQ-005 Port: load  in  1  counter load strobe, same cycle as presented to the counter.
REQ-006 Port: load_val  in  4  counter data_in, meaningful only when load=1.
REQ-007 Port: enable  in  1  tracking enable, level-sensitive.
REQ-008 Port: clr_err  in  1  clears seq_err and err_cnt.
REQ-009 Port: wrap_pulse  out  1  one-cycle pulse on a natural 15->0 rollover.
REQ-010 Port: wrap_cnt  out  8  rollover count, modulo 256.
REQ-011 Port: seq_err  out  1  sticky sequence-error flag.
REQ-012 Port: err_cnt  out  4  mismatch count, saturating at 15.
REQ-013 Port: state  out  2  FSM state: IDLE=0, SYNC=1, TRACK=2, ERROR=3.

Function
REQ-014 The block SHALL hold registers prev[3:0] (last sampled count) and ld_q/ldv_q (last sampled load/load_val).
REQ-015 Expected value: exp = ldv_q if ld_q=1, else (prev+1) mod 16.
REQ-016 IDLE: outputs hold; enable=1 -> SYNC next edge.
REQ-017 SYNC: capture prev=count_in, ld_q=load, ldv_q=load_val; no compare; -> TRACK next edge (-> IDLE if enable=0).
REQ-018 TRACK, enable=1, count_in==exp: capture prev/ld_q/ldv_q; stay in TRACK.
REQ-019 TRACK match with prev==15, count_in==0, ld_q==0: wrap_pulse=1 for exactly the following cycle; wrap_cnt increments, 255 -> 0.
REQ-020 The following SHALL NOT count as a wrap: a load of 0 from 15, or a load of any value.
REQ-021 TRACK, enable=1, count_in!=exp: seq_err=1; err_cnt+1 saturating at 15; -> ERROR; no wrap counted.
REQ-022 ERROR: no compare; -> SYNC next edge (-> IDLE if enable=0); resynchronises to the live count.
REQ-023 enable=0 in SYNC, TRACK or ERROR: -> IDLE next edge; wrap_cnt, seq_err and err_cnt hold.
REQ-024 wrap_pulse, seq_err and err_cnt SHALL be registered; they are visible one cycle after the edge sampling the triggering count.
REQ-025 clr_err=1 in any state: clears seq_err and err_cnt to 0 next edge; no effect on FSM or wrap_cnt.
REQ-026 clr_err=1 in the same cycle as a mismatch: the mismatch wins (seq_err=1, err_cnt=1).
REQ-027 wrap_pulse SHALL never be high for two consecutive cycles.

Reset
REQ-028 rst=1 at any edge: state=IDLE, prev=0, ld_q=0, ldv_q=0, wrap_pulse=0, wrap_cnt=0, seq_err=0, err_cnt=0.
REQ-029 rst mid-TRACK SHALL abort tracking without flagging an error.
REQ-030 After rst deasserts with enable=1: SYNC, then TRACK, two edges later.
REQ-031 rst SHALL take priority over enable, clr_err and all compare results.

Verification
REQ-032 Free run, enable=1, counter from 0 for 40 cycles -> wrap_pulse at 15->0 twice, wrap_cnt=2, seq_err=0.
REQ-033 load=1, load_val=9 while count=4 -> next count 9 accepted, no error; then 10, 11 ... tracked.
REQ-034 Count at 15, load=1, load_val=0 -> no wrap_pulse; wrap_cnt unchanged.
REQ-035 Force count_in to 7 when 3 expected -> seq_err=1, err_cnt=1 next cycle; state ERROR, then SYNC, then TRACK.
REQ-036 Inject 17 mismatches -> err_cnt=15; clr_err with a simultaneous mismatch -> err_cnt=1.
REQ-037 rst asserted while in TRACK with wrap_cnt=5 -> all outputs 0, state IDLE on the next edge; 256 natural wraps -> wrap_cnt returns to 0.
